// File: rtl/clock_counter_spi_master.sv
// -----------------------------------------------------------------------------
// clock_counter_spi_master
//
// Host-side SPI master for the CPLD clock counter's 4-wire serial port.
// Two transaction types:
//   read   : returns the "new count" flag and the COUNTER_BITS period count
//   update : writes the COMPARE_PPS_BITS PPS compare value
//
// Every transaction is SETUP + (HIGH,LOW) x (COMPARE_PPS_BITS+1) + FLUSH.
// FLUSH raises spi_clk once with spi_sen high, which clears the slave's
// started/update flags, so the slave is always resynchronised between
// transactions and after any reset.
//
// Optional feature: define CLOCK_COUNTER_SPI_AUTOPOLL_EN to add an idle
// timer that launches a read every POLL_CYCLES clocks, plus the poll_done
// output. Without the macro there is no timer and no poll_done port.
//
// Ports:
//   clk, reset          system clock, asynchronous active-high reset
//   start, cmd_update   launch request (sampled only when busy=0), 1=update
//   wr_data             compare value, captured on an accepted start
//   busy, done          transaction/flush in progress, 1-cycle end pulse
//   rd_valid, rd_count  flag and count returned by the last read
//   spi_clk, spi_sen    serial clock (idles low), enable (active low)
//   spi_mosi, spi_miso  serial data to / from the CPLD
//   poll_done           (autopoll only) pulses with done on auto reads
// -----------------------------------------------------------------------------
module clock_counter_spi_master #(
   parameter int CLK_DIV          = 8,
   parameter int COUNTER_BITS     = 27,
   parameter int COMPARE_PPS_BITS = 28,
   parameter int POLL_CYCLES      = 10000000
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        start,
   input  logic                        cmd_update,
   input  logic [COMPARE_PPS_BITS-1:0] wr_data,
   output logic                        busy,
   output logic                        done,
   output logic                        rd_valid,
   output logic [COUNTER_BITS-1:0]     rd_count,
   output logic                        spi_clk,
   output logic                        spi_sen,
   output logic                        spi_mosi,
   input  logic                        spi_miso
`ifdef CLOCK_COUNTER_SPI_AUTOPOLL_EN
   ,
   output logic                        poll_done
`endif
);

   // One rise for the command bit plus one per compare bit.
   localparam int NUM_RISES = COMPARE_PPS_BITS + 1;
   localparam int IDX_W     = $clog2(NUM_RISES + 1);

   localparam logic [7:0]       DIV_LAST    = 8'(CLK_DIV - 1);
   localparam logic [IDX_W-1:0] LAST_RISE   = IDX_W'(NUM_RISES);
   localparam logic [IDX_W-1:0] LAST_SAMPLE = IDX_W'(COUNTER_BITS);

   typedef enum logic [2:0] {
      S_FLUSH,
      S_IDLE,
      S_SETUP,
      S_HIGH,
      S_LOW
   } state_t;

   state_t                      state, nxt_state;
   logic [7:0]                  timer, nxt_timer;
   logic [1:0]                  fl_cnt, nxt_fl_cnt;
   logic [IDX_W-1:0]            bit_idx, nxt_bit_idx;
   logic                        is_update, nxt_is_update;
   logic                        txn, nxt_txn;       // current FLUSH ends a transaction
   logic                        flag, nxt_flag;
   logic [COMPARE_PPS_BITS-1:0] data_sr, nxt_data_sr;
   logic [COUNTER_BITS-1:0]     cnt_sr, nxt_cnt_sr;
   logic                        nxt_busy, nxt_done, nxt_rd_valid;
   logic [COUNTER_BITS-1:0]     nxt_rd_count;
   logic                        nxt_spi_clk, nxt_spi_sen, nxt_spi_mosi;
   logic                        phase_end;
   logic                        poll_fire;
   logic                        launch;

   // The timer only runs outside IDLE; every non-idle state lasts a
   // whole number of CLK_DIV-cycle half-periods.
   assign phase_end = (state != S_IDLE) && (timer == DIV_LAST);
   assign launch    = start || poll_fire;

   // ---------------------------------------------------------------------------
   // Next-state and next-output logic
   // ---------------------------------------------------------------------------
   always_comb begin
      nxt_state     = state;
      nxt_timer     = (state == S_IDLE || phase_end) ? 8'd0 : timer + 8'd1;
      nxt_fl_cnt    = fl_cnt;
      nxt_bit_idx   = bit_idx;
      nxt_is_update = is_update;
      nxt_txn       = txn;
      nxt_flag      = flag;
      nxt_data_sr   = data_sr;
      nxt_cnt_sr    = cnt_sr;
      nxt_busy      = busy;
      nxt_done      = 1'b0;
      nxt_rd_valid  = rd_valid;
      nxt_rd_count  = rd_count;
      nxt_spi_clk   = spi_clk;
      nxt_spi_sen   = spi_sen;
      nxt_spi_mosi  = spi_mosi;

      case (state)
         S_IDLE: begin
            nxt_busy = 1'b0;
            if (launch) begin
               // An external start always wins over an auto-poll launch.
               nxt_is_update = start ? cmd_update : 1'b0;
               nxt_data_sr   = start ? wr_data : '0;
               nxt_cnt_sr    = '0;
               nxt_busy      = 1'b1;
               nxt_spi_sen   = 1'b0;
               nxt_spi_clk   = 1'b0;
               nxt_spi_mosi  = start ? ~cmd_update : 1'b1;
               nxt_state     = S_SETUP;
            end
         end

         S_SETUP: begin
            if (phase_end) begin
               // Slave presents the flag as soon as sen falls.
               nxt_flag    = spi_miso;
               nxt_spi_clk = 1'b1;
               nxt_bit_idx = IDX_W'(1);
               nxt_state   = S_HIGH;
            end
         end

         S_HIGH: begin
            if (phase_end) begin
               nxt_spi_clk = 1'b0;
               nxt_state   = S_LOW;
               // Zeros shift in behind the data, so the last LOW drives 0.
               if (is_update) begin
                  nxt_spi_mosi = data_sr[COMPARE_PPS_BITS-1];
                  nxt_data_sr  = {data_sr[COMPARE_PPS_BITS-2:0], 1'b0};
               end else begin
                  nxt_spi_mosi = 1'b0;
               end
            end
         end

         S_LOW: begin
            if (phase_end) begin
               // Count bits arrive MSB first, one per LOW after the flag.
               if (!is_update && bit_idx <= LAST_SAMPLE)
                  nxt_cnt_sr = {cnt_sr[COUNTER_BITS-2:0], spi_miso};
               if (bit_idx == LAST_RISE) begin
                  nxt_spi_sen  = 1'b1;
                  nxt_spi_clk  = 1'b0;
                  nxt_spi_mosi = 1'b0;
                  nxt_fl_cnt   = 2'd0;
                  nxt_txn      = 1'b1;
                  nxt_state    = S_FLUSH;
               end else begin
                  nxt_spi_clk = 1'b1;
                  nxt_bit_idx = bit_idx + 1'b1;
                  nxt_state   = S_HIGH;
               end
            end
         end

         S_FLUSH: begin
            if (phase_end) begin
               case (fl_cnt)
                  2'd0: begin
                     nxt_spi_clk = 1'b1;
                     nxt_fl_cnt  = 2'd1;
                  end
                  2'd1: begin
                     nxt_spi_clk = 1'b0;
                     nxt_fl_cnt  = 2'd2;
                  end
                  default: begin
                     nxt_fl_cnt  = 2'd0;
                     nxt_bit_idx = '0;
                     nxt_busy    = 1'b0;
                     nxt_state   = S_IDLE;
                     // A flush after reset is silent; only transactions report.
                     if (txn) begin
                        nxt_txn  = 1'b0;
                        nxt_done = 1'b1;
                        if (!is_update) begin
                           nxt_rd_valid = flag;
                           nxt_rd_count = cnt_sr;
                        end
                     end
                  end
               endcase
            end
         end

         default: nxt_state = S_FLUSH;
      endcase
   end

   // ---------------------------------------------------------------------------
   // State and output registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= S_FLUSH;
         timer     <= '0;
         fl_cnt    <= '0;
         bit_idx   <= '0;
         is_update <= 1'b0;
         txn       <= 1'b0;
         flag      <= 1'b0;
         data_sr   <= '0;
         cnt_sr    <= '0;
         busy      <= 1'b1;
         done      <= 1'b0;
         rd_valid  <= 1'b0;
         rd_count  <= '0;
         spi_clk   <= 1'b0;
         spi_sen   <= 1'b1;
         spi_mosi  <= 1'b0;
      end else begin
         state     <= nxt_state;
         timer     <= nxt_timer;
         fl_cnt    <= nxt_fl_cnt;
         bit_idx   <= nxt_bit_idx;
         is_update <= nxt_is_update;
         txn       <= nxt_txn;
         flag      <= nxt_flag;
         data_sr   <= nxt_data_sr;
         cnt_sr    <= nxt_cnt_sr;
         busy      <= nxt_busy;
         done      <= nxt_done;
         rd_valid  <= nxt_rd_valid;
         rd_count  <= nxt_rd_count;
         spi_clk   <= nxt_spi_clk;
         spi_sen   <= nxt_spi_sen;
         spi_mosi  <= nxt_spi_mosi;
      end
   end

`ifdef CLOCK_COUNTER_SPI_AUTOPOLL_EN
   // ---------------------------------------------------------------------------
   // Auto-poll: idle-time down-counter, reloaded on every done.
   // ---------------------------------------------------------------------------
   localparam int POLL_W = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
   localparam logic [POLL_W-1:0] POLL_RELOAD = POLL_W'(POLL_CYCLES - 1);

   logic [POLL_W-1:0] poll_cnt;
   logic              poll_txn;   // transaction in flight was auto-launched

   assign poll_fire = (state == S_IDLE) && (poll_cnt == '0);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         poll_cnt  <= POLL_RELOAD;
         poll_txn  <= 1'b0;
         poll_done <= 1'b0;
      end else begin
         poll_done <= nxt_done && poll_txn;
         if (nxt_done)
            poll_cnt <= POLL_RELOAD;
         else if (state == S_IDLE && poll_cnt != '0)
            poll_cnt <= poll_cnt - 1'b1;
         if (state == S_IDLE && launch)
            poll_txn <= !start;
      end
   end
`else
   assign poll_fire = 1'b0;
`endif

endmodule

// File: tb/tb_clock_counter_spi_master.sv
// -----------------------------------------------------------------------------
// tb_clock_counter_spi_master
//
// Drives clock_counter_spi_master against a behavioural CPLD slave model.
// A table of transactions is applied in a loop; each expected read result
// is pushed to a scoreboard queue when the start is driven and popped when
// done pulses. Hand-written sequences cover the reset flush, stray starts
// while busy and a reset in the middle of a read.
// -----------------------------------------------------------------------------
module tb_clock_counter_spi_master;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        cmd_update = 1'b0;
   logic [27:0] wr_data = '0;
   logic        busy, done, rd_valid;
   logic [26:0] rd_count;
   logic        spi_clk, spi_sen, spi_mosi, spi_miso;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   clock_counter_spi_master #(
      .CLK_DIV(8), .COUNTER_BITS(27), .COMPARE_PPS_BITS(28), .POLL_CYCLES(1000)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .cmd_update(cmd_update),
      .wr_data(wr_data), .busy(busy), .done(done), .rd_valid(rd_valid),
      .rd_count(rd_count), .spi_clk(spi_clk), .spi_sen(spi_sen),
      .spi_mosi(spi_mosi), .spi_miso(spi_miso)
   );

   // ---------------- CPLD slave model ----------------
   logic        s_flag = 1'b0;
   logic [26:0] s_count = '0;
   logic [27:0] s_shift = '0;
   logic [27:0] s_cmp = '0;
   logic [28:0] s_mosi = '0;
   logic        s_read = 1'b0;
   int          rises = 0;
   int          n_lo = 0;
   int          n_hi = 0;
   logic [27:0] s_word;
   logic [4:0]  s_idx;

   always @(posedge spi_clk) begin
      if (spi_sen) begin
         rises <= 0;
         n_hi  <= n_hi + 1;
      end else begin
         rises  <= rises + 1;
         n_lo   <= n_lo + 1;
         s_mosi <= {s_mosi[27:0], spi_mosi};
         if (rises == 0) begin
            s_read <= spi_mosi;
         end else begin
            s_shift <= {s_shift[26:0], spi_mosi};
            if (rises == 28 && !s_read) s_cmp <= {s_shift[26:0], spi_mosi};
         end
      end
   end

   always_comb begin
      s_word   = {s_flag, s_count};
      s_idx    = 5'(27 - rises);
      spi_miso = 1'b0;
      if (!spi_sen && rises <= 27) spi_miso = s_word[s_idx];
   end

   int done_cnt = 0;
   always @(negedge clk) if (done) done_cnt <= done_cnt + 1;

   // ---------------- scoreboard / vectors ----------------
   typedef struct {
      logic        v;
      logic [26:0] c;
   } exp_t;
   exp_t exp_q[$];

   typedef struct {
      logic        upd;
      logic [27:0] wr;
      logic        ld;
      logic        ld_flag;
      logic [26:0] ld_cnt;
      logic        stray;
      logic        exp_valid;
      logic [26:0] exp_cnt;
      logic [27:0] exp_cmp;
   } vec_t;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Launch one transaction and wait for busy to drop. Optional stray starts
   // at busy cycles 1/100/495, or a reset at busy cycle abort_at.
   task automatic drive_and_wait(input logic upd, input logic [27:0] wr,
                                 input logic stray, input int abort_at, output int n);
      @(negedge clk);
      start = 1'b1; cmd_update = upd; wr_data = wr;
      @(negedge clk);
      start = 1'b0; cmd_update = 1'b0;
      n = 0;
      while (busy && n < 2000) begin
         n++;
         if (n == abort_at) begin
            reset = 1'b1;
            #1;
            chk("abort_sen", 64'(spi_sen), 64'(1));
            chk("abort_clk", 64'(spi_clk), 64'(0));
            chk("abort_busy", 64'(busy), 64'(1));
            chk("abort_rd_valid", 64'(rd_valid), 64'(0));
            chk("abort_rd_count", 64'(rd_count), 64'(0));
            return;
         end
         start      = stray && (n == 1 || n == 100 || n == 495);
         cmd_update = stray;
         wr_data    = stray ? 28'h0F0F0F0 : wr;
         @(negedge clk);
      end
      start = 1'b0; cmd_update = 1'b0;
   endtask

   // Release reset and check the silent 3-half-period flush.
   task automatic flush_check();
      int n, lo0, hi0, d0;
      lo0 = n_lo; hi0 = n_hi; d0 = done_cnt;
      @(negedge clk);
      reset = 1'b0;
      n = 0;
      while (busy && n < 100) begin
         n++;
         @(negedge clk);
      end
      chk("flush_busy_cycles", 64'(n), 64'(24));
      chk("flush_rises_sen_high", 64'(n_hi - hi0), 64'(1));
      chk("flush_rises_sen_low", 64'(n_lo - lo0), 64'(0));
      repeat (40) @(negedge clk);
      chk("flush_no_done", 64'(done_cnt - d0), 64'(0));
      chk("flush_idle_busy", 64'(busy), 64'(0));
   endtask

   task automatic do_vec(input vec_t v);
      int   n, lo0, hi0, d0;
      exp_t e;
      if (v.ld) begin
         s_flag  = v.ld_flag;
         s_count = v.ld_cnt;
      end
      exp_q.push_back('{v: v.exp_valid, c: v.exp_cnt});
      lo0 = n_lo; hi0 = n_hi; d0 = done_cnt;
      drive_and_wait(v.upd, v.wr, v.stray, 0, n);
      chk("busy_cycles", 64'(n), 64'(496));
      chk("done_pulse", 64'(done), 64'(1));
      e = exp_q.pop_front();
      chk("rd_valid", 64'(rd_valid), 64'(e.v));
      chk("rd_count", 64'(rd_count), 64'(e.c));
      chk("rises_sen_low", 64'(n_lo - lo0), 64'(29));
      chk("rises_sen_high", 64'(n_hi - hi0), 64'(1));
      chk("mosi_bits", 64'(s_mosi), v.upd ? 64'({1'b0, v.wr}) : 64'({1'b1, 28'h0}));
      chk("slave_cmp", 64'(s_cmp), 64'(v.exp_cmp));
      @(negedge clk);
      chk("done_one_cycle", 64'(done), 64'(0));
      if (v.stray) repeat (600) @(negedge clk);
      chk("done_count", 64'(done_cnt - d0), 64'(1));
      chk("idle_sen", 64'(spi_sen), 64'(1));
      chk("idle_clk", 64'(spi_clk), 64'(0));
      // The slave's latched count is consumed by either transaction type.
      s_flag  = 1'b0;
      s_count = '0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tbl[9];
      vec_t fin;
      int   n, lo0, hi0, d0;

      //               upd  wr             ld  flg cnt           stray ev  ecnt          ecmp
      tbl[0] = '{1'b0, 28'h0,       1'b1, 1'b1, 27'h5F5E100, 1'b0, 1'b1, 27'h5F5E100, 28'h0};
      tbl[1] = '{1'b0, 28'h0,       1'b0, 1'b0, 27'h0,       1'b0, 1'b0, 27'h0,       28'h0};
      tbl[2] = '{1'b1, 28'hABCDEF1, 1'b0, 1'b0, 27'h0,       1'b0, 1'b0, 27'h0,       28'hABCDEF1};
      tbl[3] = '{1'b0, 28'h0,       1'b1, 1'b1, 27'h0000001, 1'b0, 1'b1, 27'h0000001, 28'hABCDEF1};
      tbl[4] = '{1'b0, 28'h0,       1'b1, 1'b0, 27'h7FFFFFF, 1'b0, 1'b0, 27'h7FFFFFF, 28'hABCDEF1};
      tbl[5] = '{1'b1, 28'h5555555, 1'b1, 1'b1, 27'h1234567, 1'b0, 1'b0, 27'h7FFFFFF, 28'h5555555};
      tbl[6] = '{1'b0, 28'h0,       1'b0, 1'b0, 27'h0,       1'b0, 1'b0, 27'h0,       28'h5555555};
      tbl[7] = '{1'b1, 28'hFFFFFFF, 1'b0, 1'b0, 27'h0,       1'b0, 1'b0, 27'h0,       28'hFFFFFFF};
      tbl[8] = '{1'b0, 28'h0,       1'b1, 1'b1, 27'h2AAAAAA, 1'b1, 1'b1, 27'h2AAAAAA, 28'hFFFFFFF};

      // Reset values while reset is held.
      repeat (3) @(negedge clk);
      chk("rst_busy", 64'(busy), 64'(1));
      chk("rst_done", 64'(done), 64'(0));
      chk("rst_rd_valid", 64'(rd_valid), 64'(0));
      chk("rst_rd_count", 64'(rd_count), 64'(0));
      chk("rst_spi_clk", 64'(spi_clk), 64'(0));
      chk("rst_spi_sen", 64'(spi_sen), 64'(1));
      chk("rst_spi_mosi", 64'(spi_mosi), 64'(0));
      flush_check();

      for (int i = 0; i < 9; i++) do_vec(tbl[i]);

      // Reset in the middle of a read; the pending count must survive.
      s_flag  = 1'b1;
      s_count = 27'h3C3C3C3;
      d0 = done_cnt;
      drive_and_wait(1'b0, 28'h0, 1'b0, 200, n);
      chk("abort_cycle", 64'(n), 64'(200));
      repeat (2) @(negedge clk);
      lo0 = n_lo; hi0 = n_hi;
      flush_check();
      chk("abort_no_done", 64'(done_cnt - d0), 64'(0));
      chk("abort_no_extra_rises", 64'(n_lo - lo0), 64'(0));
      chk("abort_one_flush_rise", 64'(n_hi - hi0), 64'(1));

      fin = '{1'b0, 28'h0, 1'b0, 1'b0, 27'h0, 1'b0, 1'b1, 27'h3C3C3C3, 28'hFFFFFFF};
      do_vec(fin);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
